regfile_write_arbiter: RTL and testbench

//  Owns the single write port of the bit-cell register file (one row of cells per register).

---
 rtl/regfile_write_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Single write port of the bit-cell register file, shared round-robin by ALU (A) and load (B) writeback, plus a clear sequencer.
// Latency: a write accepted at edge n appears on rf_wen/rf_waddr/rf_wdata/rf_wdecode after edge n, for one cycle.
// Backpressure: a_ready/b_ready are combinational grants; both are held low while a clear is requested or running.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                rf_wen,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] rf_wdecode
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Last register row touched by the clear sequencer; row 0 is hardwired zero and never cleared.
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_REGS - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  // 0: A preferred on contention, 1: B preferred.
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   rf_wdecode_q, rf_wdecode_d;

  // Next-state, grant and write-port decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    clr_busy_d = clr_busy_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    a_ready    = 1'b0;
    b_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          cnt_d      = ADDR_W'(1);
          clr_busy_d = 1'b1;
        end else if (a_valid && (!b_valid || !rr_ptr_q)) begin
          a_ready  = 1'b1;
          rr_ptr_d = 1'b1;
          // Writes to row 0 complete the handshake but never strobe the array.
          if (a_addr != '0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = a_addr;
            rf_wdata_d = a_data;
          end
        end else if (b_valid) begin
          b_ready  = 1'b1;
          rr_ptr_d = 1'b0;
          if (b_addr != '0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = b_addr;
            rf_wdata_d = b_data;
          end
        end
      end
      CLEAR: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ROW) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    rf_wdecode_d = rf_wen_d ? (NUM_REGS'(1) << rf_waddr_d) : '0;
  end

  // State and registered write-port outputs; reset also aborts a clear in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= 1'b0;
      clr_busy_q   <= 1'b0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_wdecode_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      clr_busy_q   <= clr_busy_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_wdecode_q <= rf_wdecode_d;
    end
  end

  assign clr_busy   = clr_busy_q;
  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_wdecode = rf_wdecode_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, clr_req;
  logic        a_ready, b_ready, clr_busy, rf_wen;
  logic [3:0]  a_addr, b_addr, rf_waddr;
  logic [15:0] a_data, b_data, rf_wdata, rf_wdecode;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wdecode(rf_wdecode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_valid = 0; b_valid = 0; clr_req = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    tick(); tick();
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_wdecode", rf_wdecode, 0);
    chk("rst_busy", clr_busy, 0);
    rst = 1'b0;

    // 1: single A write r3=0x1234
    a_valid = 1; a_addr = 4'd3; a_data = 16'h1234; settle();
    chk("t1_a_ready", a_ready, 1);
    chk("t1_b_ready", b_ready, 0);
    tick(); a_valid = 0;
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 16'h1234);
    chk("t1_wdecode", rf_wdecode, 16'h0008);
    tick();
    chk("t1_idle_wen", rf_wen, 0);
    chk("t1_idle_wdecode", rf_wdecode, 0);
    chk("t1_hold_waddr", rf_waddr, 3);
    chk("t1_hold_wdata", rf_wdata, 16'h1234);

    // 2: contention after reset, A,B,A,B
    do_reset();
    a_valid = 1; a_addr = 4'd5; a_data = 16'hAAAA;
    b_valid = 1; b_addr = 4'd6; b_data = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      chk("t2_wen", rf_wen, 1);
      chk("t2_waddr", rf_waddr, (i % 2 == 0) ? 5 : 6);
      chk("t2_wdata", rf_wdata, (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
    end
    a_valid = 0; b_valid = 0;

    // 3: A write (ptr -> B), then B write to r0 (ptr -> A), then contention -> A
    a_valid = 1; a_addr = 4'd2; a_data = 16'h0202; tick(); a_valid = 0;
    b_valid = 1; b_addr = 4'd0; b_data = 16'hFFFF; settle();
    chk("t3_b_ready_r0", b_ready, 1);
    tick(); b_valid = 0;
    chk("t3_r0_wen", rf_wen, 0);
    chk("t3_r0_wdecode", rf_wdecode, 0);
    a_valid = 1; a_addr = 4'd9; a_data = 16'h0909;
    b_valid = 1; b_addr = 4'd10; b_data = 16'h1010; settle();
    chk("t3_ctd_a_ready", a_ready, 1);
    chk("t3_ctd_b_ready", b_ready, 0);
    tick(); a_valid = 0; b_valid = 0;
    chk("t3_ctd_waddr", rf_waddr, 9);

    // 4: clear with A pending (pointer now favours B, only A valid)
    clr_req = 1; a_valid = 1; a_addr = 4'd7; a_data = 16'h0777; settle();
    chk("t4_req_a_ready", a_ready, 0);
    tick(); clr_req = 0;
    for (int c = 0; c < 15; c++) begin
      chk("t4_busy", clr_busy, 1);
      chk("t4_a_ready", a_ready, 0);
      if (c >= 1) begin
        chk("t4_wen", rf_wen, 1);
        chk("t4_waddr", rf_waddr, c);
        chk("t4_wdata", rf_wdata, 0);
        chk("t4_wdecode", rf_wdecode, 32'd1 << c);
      end
      tick();
    end
    chk("t4_end_busy", clr_busy, 0);
    chk("t4_end_wen", rf_wen, 1);
    chk("t4_end_waddr", rf_waddr, 15);
    chk("t4_end_wdecode", rf_wdecode, 16'h8000);
    chk("t4_end_a_ready", a_ready, 1);
    tick(); a_valid = 0;
    chk("t4_a_wen", rf_wen, 1);
    chk("t4_a_waddr", rf_waddr, 7);
    chk("t4_a_wdata", rf_wdata, 16'h0777);

    // 5: reset on the 5th clear cycle (pointer currently favours B)
    clr_req = 1; tick(); clr_req = 0;
    tick(); tick(); tick(); tick();
    chk("t5_busy_before", clr_busy, 1);
    rst = 1; tick(); rst = 0;
    chk("t5_busy", clr_busy, 0);
    chk("t5_wen", rf_wen, 0);
    chk("t5_wdecode", rf_wdecode, 0);
    a_valid = 1; a_addr = 4'd4; a_data = 16'h4444;
    b_valid = 1; b_addr = 4'd8; b_data = 16'h8888; settle();
    chk("t5_first_a", a_ready, 1);
    chk("t5_first_b", b_ready, 0);
    tick();
    chk("t5_first_waddr", rf_waddr, 4);
    chk("t5_second_b", b_ready, 1);
    chk("t5_second_a", a_ready, 0);
    tick();
    chk("t5_second_waddr", rf_waddr, 8);

    // 6: both held valid (pointer back on A): B served within 2 cycles, no starvation
    begin
      int a_cnt, b_cnt;
      a_cnt = 0; b_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        if (a_ready) a_cnt++;
        if (b_ready) b_cnt++;
        if (i == 1) chk("t6_b_within2", b_cnt, 1);
        tick();
      end
      chk("t6_a_cnt", a_cnt, 3);
      chk("t6_b_cnt", b_cnt, 3);
    end
    a_valid = 0; b_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
